// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and oversampling constants for rx_mod and tx_mod
package uart_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t DATA  = 2'd2;
  localparam state_t STOP  = 2'd3;
  localparam int OVERSAMPLE     = 16;
  localparam int MID_TICK       = 7;
  localparam int NB_DATA_DEF    = 8;
  localparam int STOP_TICKS_DEF = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs with a configurable reset value
module sync_2ff #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] meta_q, sync_q;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end
  assign o_q = sync_q;
endmodule

// File: rtl/rx_mod.sv
// rx_mod: UART receiver, 16x oversampled, mid-bit sampling, registered done pulse and framing error
module rx_mod
  import uart_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int STOP_TICKS = STOP_TICKS_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done_tick,
  output logic               o_frame_err
);
  localparam int BW = $clog2(NB_DATA);
  localparam logic [3:0] MID       = 4'(MID_TICK);
  localparam logic [3:0] LAST      = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB_DATA - 1);
  logic rx_s, rx_prev_q;
  state_t state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [NB_DATA-1:0] shift_q, shift_d, data_q, data_d;
  logic done_q, done_d, err_q, err_d;
  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_rx),
    .o_q       (rx_s)
  );
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  // only a high-to-low transition starts a frame, so a held-low (break) line is ignored
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (rx_prev_q && !rx_s) begin
        state_d = START;
        tick_d  = '0;
      end
      START: if (i_s_tick) begin
        if (tick_q == MID) begin
          state_d = rx_s ? IDLE : DATA;
          tick_d  = '0;
          bit_d   = '0;
        end else tick_d = tick_q + 4'd1;
      end
      DATA: if (i_s_tick) begin
        if (tick_q == LAST) begin
          tick_d  = '0;
          shift_d = {rx_s, shift_q[NB_DATA-1:1]};
          state_d = (bit_q == BIT_LAST) ? STOP : DATA;
          bit_d   = (bit_q == BIT_LAST) ? bit_q : bit_q + 1'b1;
        end else tick_d = tick_q + 4'd1;
      end
      STOP: if (i_s_tick) begin
        if (tick_q == STOP_LAST) begin
          state_d = IDLE;
          data_d  = shift_q;
          err_d   = ~rx_s;
          done_d  = 1'b1;
        end else tick_d = tick_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign o_rx_data      = data_q;
  assign o_rx_done_tick = done_q;
  assign o_frame_err    = err_q;
endmodule

// File: tb/tb_rx_mod.sv
// tb_rx_mod: randomized frame driver with a queue-based expected-frame model for rx_mod (8-bit and 7-bit)
module tb_rx_mod;
  typedef struct packed {logic [7:0] d; logic e;} rec_t;
  localparam int BIT_CLKS = 64;
  logic clk = 1'b0, rst_n = 1'b0, rx8 = 1'b1, rx7 = 1'b1;
  logic [1:0] tcnt = 2'd0;
  logic s_tick;
  logic [7:0] data8;
  logic [6:0] data7;
  logic done8, done7, err8, err7;
  int vectors = 0, errs = 0, pcnt = 0;
  bit tick_hist [0:131071];
  rec_t got8[$];
  logic [6:0] got7[$];
  int done7_idx[$];
  always #5 clk = ~clk;
  assign s_tick = (tcnt == 2'd3);
  always @(posedge clk) begin
    tcnt <= tcnt + 2'd1;
    tick_hist[pcnt] <= s_tick;
    pcnt <= pcnt + 1;
  end
  rx_mod dut8 (
    .i_clk(clk), .i_reset_n(rst_n), .i_s_tick(s_tick), .i_rx(rx8),
    .o_rx_data(data8), .o_rx_done_tick(done8), .o_frame_err(err8)
  );
  rx_mod #(.NB_DATA(7), .STOP_TICKS(16)) dut7 (
    .i_clk(clk), .i_reset_n(rst_n), .i_s_tick(s_tick), .i_rx(rx7),
    .o_rx_data(data7), .o_rx_done_tick(done7), .o_frame_err(err7)
  );
  always @(negedge clk) begin
    if (done8) got8.push_back({data8, err8});
    if (done7) begin
      got7.push_back(data7);
      done7_idx.push_back(pcnt - 1);
    end
  end
  task automatic drive(input logic v, input bit sel);
    if (sel) rx7 = v; else rx8 = v;
  endtask
  task automatic send_frame(input logic [7:0] d, input int nb, input bit stop_hi, input int stop_len, input bit sel);
    drive(1'b0, sel);
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      drive(d[i], sel);
      repeat (BIT_CLKS) @(negedge clk);
    end
    drive(stop_hi, sel);
    repeat (stop_len) @(negedge clk);
    drive(1'b1, sel);
  endtask
  task automatic test_reset;
    repeat (4) @(negedge clk);
    vectors++; if ({data8, done8, err8} !== 10'd0) begin errs++; $display("FAIL reset_out8 got %h exp 000", {data8, done8, err8}); end
    vectors++; if ({data7, done7, err7} !== 9'd0) begin errs++; $display("FAIL reset_out7 got %h exp 000", {data7, done7, err7}); end
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (got8.size() !== 0) begin errs++; $display("FAIL reset_idle_done got %0d exp 0", got8.size()); end
  endtask
  task automatic test_single;
    got8.delete();
    send_frame(8'hA5, 8, 1'b1, BIT_CLKS, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (got8.size() !== 1) begin errs++; $display("FAIL single_count got %0d exp 1", got8.size()); end
    vectors++; if ({data8, err8} !== {8'hA5, 1'b0}) begin errs++; $display("FAIL single_data got %h/%b exp a5/0", data8, err8); end
  endtask
  task automatic test_back_to_back;
    rec_t exp[$];
    got8.delete();
    exp = '{{8'h00, 1'b0}, {8'hFF, 1'b0}, {8'h3C, 1'b0}};
    send_frame(8'h00, 8, 1'b1, BIT_CLKS, 1'b0);
    send_frame(8'hFF, 8, 1'b1, 48, 1'b0);
    send_frame(8'h3C, 8, 1'b1, BIT_CLKS, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (got8.size() !== 3) begin errs++; $display("FAIL b2b_count got %0d exp 3", got8.size()); end
    for (int i = 0; i < 3; i++) begin
      rec_t g = (i < got8.size()) ? got8[i] : 9'h1ff;
      vectors++; if (g !== exp[i]) begin errs++; $display("FAIL b2b_frame%0d got %h/%b exp %h/%b", i, g.d, g.e, exp[i].d, exp[i].e); end
    end
  endtask
  task automatic test_break;
    logic [7:0] r = 8'($urandom);
    got8.delete();
    send_frame(8'h5A, 8, 1'b0, BIT_CLKS, 1'b0);
    rx8 = 1'b0;
    repeat (30 * BIT_CLKS) @(negedge clk);
    vectors++; if (got8.size() !== 1) begin errs++; $display("FAIL break_count got %0d exp 1", got8.size()); end
    vectors++; if ({data8, err8} !== {8'h5A, 1'b1}) begin errs++; $display("FAIL break_ferr got %h/%b exp 5a/1", data8, err8); end
    rx8 = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (got8.size() !== 1) begin errs++; $display("FAIL break_release got %0d exp 1", got8.size()); end
    send_frame(r, 8, 1'b1, BIT_CLKS, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if ({got8.size(), data8, err8} !== {32'd2, r, 1'b0}) begin errs++; $display("FAIL break_recover got %0d:%h/%b exp 2:%h/0", got8.size(), data8, err8, r); end
  endtask
  task automatic test_glitch;
    got8.delete();
    rx8 = 1'b0;
    repeat (16) @(negedge clk);
    rx8 = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    vectors++; if (got8.size() !== 0) begin errs++; $display("FAIL glitch_count got %0d exp 0", got8.size()); end
    send_frame(8'h81, 8, 1'b1, BIT_CLKS, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if ({got8.size(), data8, err8} !== {32'd1, 8'h81, 1'b0}) begin errs++; $display("FAIL glitch_recover got %0d:%h/%b exp 1:81/0", got8.size(), data8, err8); end
  endtask
  task automatic test_reset_mid;
    logic [7:0] d = 8'h96;
    got8.delete();
    rx8 = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx8 = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx8 = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if ({data8, done8, err8} !== 10'd0) begin errs++; $display("FAIL midreset_out got %h exp 000", {data8, done8, err8}); end
    rst_n = 1'b1;
    rx8 = 1'b1;
    repeat (11 * BIT_CLKS) @(negedge clk);
    vectors++; if (got8.size() !== 0) begin errs++; $display("FAIL midreset_done got %0d exp 0", got8.size()); end
    send_frame(8'h69, 8, 1'b1, BIT_CLKS, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if ({got8.size(), data8, err8} !== {32'd1, 8'h69, 1'b0}) begin errs++; $display("FAIL midreset_recover got %0d:%h/%b exp 1:69/0", got8.size(), data8, err8); end
  endtask
  task automatic test_random;
    rec_t exp[$];
    got8.delete();
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d = 8'($urandom);
      bit ok = ($urandom_range(0, 3) != 0);
      send_frame(d, 8, ok, ok ? $urandom_range(48, BIT_CLKS) : BIT_CLKS, 1'b0);
      exp.push_back({d, ~ok});
      repeat ($urandom_range(ok ? 0 : 4, 40)) @(negedge clk);
    end
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (got8.size() !== exp.size()) begin errs++; $display("FAIL rand_count got %0d exp %0d", got8.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      rec_t g = (i < got8.size()) ? got8[i] : ~exp[i];
      vectors++; if (g !== exp[i]) begin errs++; $display("FAIL rand_frame%0d got %h/%b exp %h/%b", i, g.d, g.e, exp[i].d, exp[i].e); end
    end
  endtask
  task automatic test_nb7;
    int s, k, n;
    logic [6:0] r = 7'($urandom);
    s = pcnt;
    send_frame(8'h55, 7, 1'b1, BIT_CLKS, 1'b1);
    send_frame({1'b0, r}, 7, 1'b1, BIT_CLKS, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (got7.size() !== 2) begin errs++; $display("FAIL nb7_count got %0d exp 2", got7.size()); end
    vectors++; if ((got7.size() > 0 ? got7[0] : 7'h7f) !== 7'h55) begin errs++; $display("FAIL nb7_data0 got %h exp 55", got7.size() > 0 ? got7[0] : 7'h7f); end
    vectors++; if ((got7.size() > 1 ? got7[1] : ~r) !== r) begin errs++; $display("FAIL nb7_data1 got %h exp %h", got7.size() > 1 ? got7[1] : ~r, r); end
    // frame is recognised on the 3rd edge after the line falls; ticks count from the edge after that
    k = (done7_idx.size() > 0) ? done7_idx[0] : s + 2;
    n = 0;
    for (int p = s + 3; p <= k; p++) n += int'(tick_hist[p]);
    vectors++; if (n !== 8 + 16 * 7 + 16 || !tick_hist[k]) begin errs++; $display("FAIL nb7_latency got %0d ticks (last edge tick=%b) exp 136 ticks ending on a tick", n, tick_hist[k]); end
    vectors++; if (got8.size() !== 0) begin errs++; $display("FAIL nb7_crosstalk got %0d exp 0", got8.size()); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_break;
    test_glitch;
    test_reset_mid;
    test_random;
    got8.delete();
    test_nb7;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
